// File: rtl/rib_pkg.sv
// Shared RIB bus widths, defaults and the request bundle
// carried through the peripheral bridge.
package rib_pkg;

  localparam int RIB_AW = 32;
  localparam int RIB_DW = 32;
  localparam int RIB_MW = 4;

  localparam logic [RIB_DW-1:0] RIB_ERR_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [RIB_AW-1:0] addr;
    logic              wrcs;
    logic [RIB_MW-1:0] mask;
    logic [RIB_DW-1:0] wdata;
    logic              err;
  } rib_req_t;

endpackage

// File: rtl/rib_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is the
// oldest entry, push ignored when full, pop ignored when empty.
module rib_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign o_head  = mem_q[rd_q[AW-1:0]];
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  // Next pointers and storage contents.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = i_data;
      wr_d = wr_q + PW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PW'(1);
    end
  end

  // Pointer and storage registers; storage clears so the head reads 0 after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/rib_periph_bridge.sv
// Buffering RIB bridge in front of the peripheral top: request/response
// FIFOs, outstanding-credit limit and local error answers outside the window.
module rib_periph_bridge
  import rib_pkg::*;
#(
  parameter int                MAX_OUTS  = 4,
  parameter int                REQ_DEPTH = 2,
  parameter logic [3:0]        WIN_TAG   = 4'hF,
  parameter logic [RIB_DW-1:0] ERR_DATA  = RIB_ERR_DATA
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [RIB_AW-1:0] i_s_addr,
  input  logic              i_s_wrcs,
  input  logic [RIB_MW-1:0] i_s_mask,
  input  logic [RIB_DW-1:0] i_s_wdata,
  input  logic              i_s_req,
  output logic              o_s_gnt,
  output logic [RIB_DW-1:0] o_s_rdata,
  output logic              o_s_rsp,
  input  logic              i_s_rdy,
  output logic [RIB_AW-1:0] o_m_addr,
  output logic              o_m_wrcs,
  output logic [RIB_MW-1:0] o_m_mask,
  output logic [RIB_DW-1:0] o_m_wdata,
  output logic              o_m_req,
  input  logic              i_m_gnt,
  input  logic [RIB_DW-1:0] i_m_rdata,
  input  logic              i_m_rsp,
  output logic              o_m_rdy,
  output logic              o_err
);

  localparam int            CW    = $clog2(MAX_OUTS + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTS);

  rib_req_t          req_in;
  rib_req_t          req_head;
  logic              req_full;
  logic              req_empty;
  logic              req_pop;
  logic              accept;

  logic              rsp_full;
  logic              rsp_empty;
  logic              rsp_push;
  logic              rsp_pop;
  logic [RIB_DW-1:0] rsp_din;

  logic              head_vld;
  logic              issue;
  logic              err_pop;
  logic              retire;
  logic              stray;

  logic [CW-1:0]     outs_q, outs_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic              err_q, err_d;

  assign o_s_gnt = i_s_req & ~req_full & (outs_q < MAX_C);
  assign accept  = i_s_req & o_s_gnt;

  assign req_in.addr  = i_s_addr;
  assign req_in.wrcs  = i_s_wrcs;
  assign req_in.mask  = i_s_mask;
  assign req_in.wdata = i_s_wdata;
  assign req_in.err   = (i_s_addr[31:28] != WIN_TAG);

  assign head_vld = ~req_empty;
  assign o_m_req  = head_vld & ~req_head.err;
  assign issue    = o_m_req & i_m_gnt;
  // An error head waits for the pipe to drain so its answer stays in order.
  assign err_pop  = head_vld & req_head.err & (inflight_q == '0);
  assign req_pop  = issue | err_pop;

  assign o_m_addr  = req_head.addr;
  assign o_m_wrcs  = req_head.wrcs;
  assign o_m_mask  = req_head.mask;
  assign o_m_wdata = req_head.wdata;

  assign o_m_rdy  = ~rsp_full;
  assign retire   = i_m_rsp & o_m_rdy & (inflight_q != '0);
  assign stray    = i_m_rsp & (inflight_q == '0);
  assign rsp_push = err_pop | retire;
  assign rsp_din  = err_pop ? ERR_DATA : i_m_rdata;

  assign o_s_rsp = ~rsp_empty;
  assign rsp_pop = o_s_rsp & i_s_rdy;
  assign o_err   = err_q;

  rib_sync_fifo #(
    .WIDTH ($bits(rib_req_t)),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (accept),
    .i_data  (req_in),
    .i_pop   (req_pop),
    .o_full  (req_full),
    .o_empty (req_empty),
    .o_head  (req_head)
  );

  rib_sync_fifo #(
    .WIDTH (RIB_DW),
    .DEPTH (MAX_OUTS)
  ) u_rsp_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (rsp_push),
    .i_data  (rsp_din),
    .i_pop   (rsp_pop),
    .o_full  (rsp_full),
    .o_empty (rsp_empty),
    .o_head  (o_s_rdata)
  );

  // Credit and in-flight counters plus the error pulse source.
  always_comb begin
    outs_d     = outs_q;
    inflight_d = inflight_q;
    unique case ({accept, rsp_pop})
      2'b10:   outs_d = outs_q + CW'(1);
      2'b01:   outs_d = outs_q - CW'(1);
      default: outs_d = outs_q;
    endcase
    unique case ({issue, retire})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    err_d = err_pop | stray;
  end

  // Counter and pulse registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      outs_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      outs_q     <= outs_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_rib_periph_bridge.sv
// Directed bench for rib_periph_bridge: ordering, credits,
// window errors, back-pressure and reset recovery.
module tb_rib_periph_bridge;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_s_addr;
  logic        i_s_wrcs;
  logic [3:0]  i_s_mask;
  logic [31:0] i_s_wdata;
  logic        i_s_req;
  logic        o_s_gnt;
  logic [31:0] o_s_rdata;
  logic        o_s_rsp;
  logic        i_s_rdy;
  logic [31:0] o_m_addr;
  logic        o_m_wrcs;
  logic [3:0]  o_m_mask;
  logic [31:0] o_m_wdata;
  logic        o_m_req;
  logic        i_m_gnt;
  logic [31:0] i_m_rdata;
  logic        i_m_rsp;
  logic        o_m_rdy;
  logic        o_err;

  int checks;
  int errors;

  rib_periph_bridge dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_s_addr  (i_s_addr),
    .i_s_wrcs  (i_s_wrcs),
    .i_s_mask  (i_s_mask),
    .i_s_wdata (i_s_wdata),
    .i_s_req   (i_s_req),
    .o_s_gnt   (o_s_gnt),
    .o_s_rdata (o_s_rdata),
    .o_s_rsp   (o_s_rsp),
    .i_s_rdy   (i_s_rdy),
    .o_m_addr  (o_m_addr),
    .o_m_wrcs  (o_m_wrcs),
    .o_m_mask  (o_m_mask),
    .o_m_wdata (o_m_wdata),
    .o_m_req   (o_m_req),
    .i_m_gnt   (i_m_gnt),
    .i_m_rdata (i_m_rdata),
    .i_m_rsp   (i_m_rsp),
    .o_m_rdy   (o_m_rdy),
    .o_err     (o_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic w,
                     input logic [31:0] d);
    i_s_req   = 1'b1;
    i_s_addr  = a;
    i_s_wrcs  = w;
    i_s_wdata = d;
    i_s_mask  = 4'hF;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_gnt"}, 32'(o_s_gnt), 32'd0);
    chk({tag, "_srsp"}, 32'(o_s_rsp), 32'd0);
    chk({tag, "_mreq"}, 32'(o_m_req), 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
    chk({tag, "_mrdy"}, 32'(o_m_rdy), 32'd1);
    chk({tag, "_rdata"}, o_s_rdata, 32'd0);
    chk({tag, "_maddr"}, o_m_addr, 32'd0);
    chk({tag, "_mwdata"}, o_m_wdata, 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    i_rst     = 1'b1;
    i_s_addr  = '0;
    i_s_wrcs  = 1'b0;
    i_s_mask  = '0;
    i_s_wdata = '0;
    i_s_req   = 1'b0;
    i_s_rdy   = 1'b1;
    i_m_gnt   = 1'b0;
    i_m_rdata = '0;
    i_m_rsp   = 1'b0;

    // reset state
    #2;
    chk_reset_outs("rst0");
    tick();
    tick();
    i_rst = 1'b0;
    tick();

    // T1: in-window read, immediate grant, response next cycle
    put(32'hF100_0004, 1'b0, 32'h0);
    i_m_gnt = 1'b1;
    #1;
    chk("t1_gnt", 32'(o_s_gnt), 32'd1);
    chk("t1_mreq0", 32'(o_m_req), 32'd0);
    tick();
    i_s_req = 1'b0;
    #1;
    chk("t1_mreq1", 32'(o_m_req), 32'd1);
    chk("t1_maddr", o_m_addr, 32'hF100_0004);
    tick();
    i_m_gnt   = 1'b0;
    i_m_rsp   = 1'b1;
    i_m_rdata = 32'h1234_5678;
    #1;
    chk("t1_mreq_gone", 32'(o_m_req), 32'd0);
    tick();
    i_m_rsp = 1'b0;
    #1;
    chk("t1_srsp", 32'(o_s_rsp), 32'd1);
    chk("t1_rdata", o_s_rdata, 32'h1234_5678);
    tick();
    chk("t1_srsp_done", 32'(o_s_rsp), 32'd0);
    chk("t1_outs", 32'(dut.outs_q), 32'd0);
    chk("t1_err", 32'(o_err), 32'd0);

    // T2: downstream stalled, five back-to-back requests
    i_m_gnt = 1'b0;
    put(32'hF000_0010, 1'b0, 32'h0);
    #1;
    chk("t2_gnt0", 32'(o_s_gnt), 32'd1);
    tick();
    put(32'hF000_0014, 1'b0, 32'h0);
    #1;
    chk("t2_gnt1", 32'(o_s_gnt), 32'd1);
    chk("t2_maddr0", o_m_addr, 32'hF000_0010);
    tick();
    put(32'hF000_0018, 1'b0, 32'h0);
    #1;
    chk("t2_gnt2_full", 32'(o_s_gnt), 32'd0);
    tick();
    i_m_gnt = 1'b1;
    #1;
    chk("t2_gnt2_full2", 32'(o_s_gnt), 32'd0);
    chk("t2_mreq", 32'(o_m_req), 32'd1);
    tick();
    #1;
    chk("t2_gnt2", 32'(o_s_gnt), 32'd1);
    chk("t2_maddr1", o_m_addr, 32'hF000_0014);
    tick();
    put(32'hF000_001C, 1'b0, 32'h0);
    #1;
    chk("t2_gnt3", 32'(o_s_gnt), 32'd1);
    tick();
    put(32'hF000_0020, 1'b0, 32'h0);
    #1;
    chk("t2_gnt4_cred", 32'(o_s_gnt), 32'd0);
    chk("t2_outs4", 32'(dut.outs_q), 32'd4);
    tick();
    i_m_gnt   = 1'b0;
    i_m_rsp   = 1'b1;
    i_m_rdata = 32'hA0A0_0000;
    #1;
    chk("t2_gnt4_cred2", 32'(o_s_gnt), 32'd0);
    chk("t2_mreq_empty", 32'(o_m_req), 32'd0);
    tick();
    i_m_rsp = 1'b0;
    #1;
    chk("t2_r0", o_s_rdata, 32'hA0A0_0000);
    chk("t2_r0v", 32'(o_s_rsp), 32'd1);
    chk("t2_gnt4_pre", 32'(o_s_gnt), 32'd0);
    chk("t2_outs_max", 32'(dut.outs_q), 32'd4);
    tick();
    #1;
    chk("t2_gnt4", 32'(o_s_gnt), 32'd1);
    tick();
    i_s_req   = 1'b0;
    i_m_gnt   = 1'b1;
    i_m_rsp   = 1'b1;
    i_m_rdata = 32'hA1A1_0001;
    #1;
    chk("t2_maddr4", o_m_addr, 32'hF000_0020);
    tick();
    i_m_gnt   = 1'b0;
    i_m_rdata = 32'hA2A2_0002;
    #1;
    chk("t2_r1", o_s_rdata, 32'hA1A1_0001);
    tick();
    i_m_rdata = 32'hA3A3_0003;
    #1;
    chk("t2_r2", o_s_rdata, 32'hA2A2_0002);
    tick();
    i_m_rdata = 32'hA4A4_0004;
    #1;
    chk("t2_r3", o_s_rdata, 32'hA3A3_0003);
    tick();
    i_m_rsp = 1'b0;
    #1;
    chk("t2_r4", o_s_rdata, 32'hA4A4_0004);
    chk("t2_r4v", 32'(o_s_rsp), 32'd1);
    tick();
    chk("t2_drained", 32'(o_s_rsp), 32'd0);
    chk("t2_outs0", 32'(dut.outs_q), 32'd0);
    chk("t2_noerr", 32'(o_err), 32'd0);

    // T3: out-of-window read answered locally
    put(32'h2000_0000, 1'b0, 32'h0);
    #1;
    chk("t3_gnt", 32'(o_s_gnt), 32'd1);
    tick();
    i_s_req = 1'b0;
    #1;
    chk("t3_mreq", 32'(o_m_req), 32'd0);
    chk("t3_err_early", 32'(o_err), 32'd0);
    tick();
    chk("t3_err", 32'(o_err), 32'd1);
    chk("t3_srsp", 32'(o_s_rsp), 32'd1);
    chk("t3_rdata", o_s_rdata, 32'hDEAD_BEEF);
    chk("t3_mreq2", 32'(o_m_req), 32'd0);
    tick();
    chk("t3_err_once", 32'(o_err), 32'd0);
    chk("t3_srsp_done", 32'(o_s_rsp), 32'd0);

    // T4: error response ordered behind a pending peripheral write
    i_m_gnt = 1'b1;
    put(32'hF100_0000, 1'b1, 32'h55AA_33CC);
    #1;
    chk("t4_gnt_w", 32'(o_s_gnt), 32'd1);
    tick();
    put(32'h1000_0000, 1'b0, 32'h0);
    #1;
    chk("t4_gnt_r", 32'(o_s_gnt), 32'd1);
    chk("t4_mwrcs", 32'(o_m_wrcs), 32'd1);
    chk("t4_mwdata", o_m_wdata, 32'h55AA_33CC);
    tick();
    i_s_req = 1'b0;
    i_m_gnt = 1'b0;
    #1;
    chk("t4_mreq_err", 32'(o_m_req), 32'd0);
    tick();
    chk("t4_wait_err", 32'(o_err), 32'd0);
    chk("t4_wait_rsp", 32'(o_s_rsp), 32'd0);
    i_m_rsp   = 1'b1;
    i_m_rdata = 32'hCAFE_0001;
    tick();
    i_m_rsp = 1'b0;
    #1;
    chk("t4_first", o_s_rdata, 32'hCAFE_0001);
    chk("t4_first_v", 32'(o_s_rsp), 32'd1);
    chk("t4_first_noerr", 32'(o_err), 32'd0);
    tick();
    chk("t4_err", 32'(o_err), 32'd1);
    chk("t4_second", o_s_rdata, 32'hDEAD_BEEF);
    chk("t4_second_v", 32'(o_s_rsp), 32'd1);
    tick();
    chk("t4_err_off", 32'(o_err), 32'd0);
    chk("t4_empty", 32'(o_s_rsp), 32'd0);

    // T5: upstream back-pressure fills the response FIFO
    i_s_rdy = 1'b0;
    i_m_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      put(32'hF200_0000 + 32'(4 * k), 1'b0, 32'h0);
      #1;
      chk("t5_gnt", 32'(o_s_gnt), 32'd1);
      tick();
    end
    i_s_req = 1'b0;
    tick();
    i_m_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_m_rsp   = 1'b1;
      i_m_rdata = 32'hB000_0000 + 32'(k);
      #1;
      chk("t5_mrdy_open", 32'(o_m_rdy), 32'd1);
      tick();
    end
    i_m_rsp = 1'b0;
    #1;
    chk("t5_mrdy_full", 32'(o_m_rdy), 32'd0);
    chk("t5_hold", o_s_rdata, 32'hB000_0000);
    tick();
    chk("t5_hold2", o_s_rdata, 32'hB000_0000);
    chk("t5_still_full", 32'(o_m_rdy), 32'd0);
    i_s_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t5_rsp_v", 32'(o_s_rsp), 32'd1);
      chk("t5_rsp_d", o_s_rdata, 32'hB000_0000 + 32'(k));
      tick();
    end
    chk("t5_empty", 32'(o_s_rsp), 32'd0);
    chk("t5_mrdy_back", 32'(o_m_rdy), 32'd1);

    // T6: reset mid-burst, then a stray response
    i_m_gnt = 1'b1;
    put(32'hF300_0000, 1'b0, 32'h0);
    tick();
    put(32'hF300_0004, 1'b0, 32'h0);
    tick();
    i_s_req = 1'b0;
    i_m_gnt = 1'b0;
    #1;
    chk("t6_busy", 32'(o_m_req), 32'd1);
    i_rst = 1'b1;
    #1;
    chk_reset_outs("t6_rst");
    tick();
    i_rst = 1'b0;
    tick();
    chk("t6_outs", 32'(dut.outs_q), 32'd0);
    i_m_rsp   = 1'b1;
    i_m_rdata = 32'h7777_7777;
    #1;
    chk("t6_mrdy", 32'(o_m_rdy), 32'd1);
    tick();
    i_m_rsp = 1'b0;
    #1;
    chk("t6_stray_err", 32'(o_err), 32'd1);
    chk("t6_stray_drop", 32'(o_s_rsp), 32'd0);
    tick();
    chk("t6_err_once", 32'(o_err), 32'd0);
    chk("t6_still_empty", 32'(o_s_rsp), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
